// File: rtl/fm_wm_mac_sequencer_if.sv
// Bundle between the FM x WM MAC sequencer and its memories/controller.
// master: the sequencer (drives addresses, result writes, status).
// slave: the environment (drives start and the asynchronous read data).
interface fm_wm_mac_sequencer_if #(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_COLS    = 3,
  parameter int DATA_WIDTH     = 5,
  parameter int DOT_PROD_WIDTH = 16
);
  localparam int ROW_W  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COL_W  = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
  localparam int WCOL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;

  logic                      start;
  logic [ROW_W-1:0]          feature_row_addr;
  logic [COL_W-1:0]          feature_col_addr;
  logic [WCOL_W-1:0]         weight_col_addr;
  logic [DATA_WIDTH-1:0]     feature_data;
  logic [DATA_WIDTH-1:0]     weight_data;
  logic [ROW_W-1:0]          write_row;
  logic [WCOL_W-1:0]         write_col;
  logic                      wr_en;
  logic [DOT_PROD_WIDTH-1:0] fm_wm_in;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, feature_data, weight_data,
    output feature_row_addr, feature_col_addr, weight_col_addr,
    output write_row, write_col, wr_en, fm_wm_in, busy, done
  );

  modport slave (
    output start, feature_data, weight_data,
    input  feature_row_addr, feature_col_addr, weight_col_addr,
    input  write_row, write_col, wr_en, fm_wm_in, busy, done
  );
endinterface

// File: rtl/fm_wm_mac_sequencer.sv
// Sequencer computing result = FM x WM one element at a time: FEATURE_COLS
// MAC cycles then one WRITE cycle per element, row-major, then a DONE pulse.
// start is only sampled in IDLE; outputs are decoded from the state register.
module fm_wm_mac_sequencer #(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_COLS    = 3,
  parameter int DATA_WIDTH     = 5,
  parameter int DOT_PROD_WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  fm_wm_mac_sequencer_if.master bus
);
  localparam int ROW_W  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int COL_W  = (FEATURE_COLS > 1) ? $clog2(FEATURE_COLS) : 1;
  localparam int WCOL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0]  K_LAST   = COL_W'(FEATURE_COLS - 1);
  localparam logic [WCOL_W-1:0] COL_LAST = WCOL_W'(WEIGHT_COLS - 1);

  logic [1:0]                state;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          k;
  logic [WCOL_W-1:0]         col;
  logic [DOT_PROD_WIDTH-1:0] acc;
  logic [PROD_W-1:0]         prod;

  // Full-width unsigned product; the accumulator add wraps modulo 2^DOT_PROD_WIDTH.
  assign prod = PROD_W'(bus.feature_data) * PROD_W'(bus.weight_data);

  // State, element counters and accumulator; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      row   <= '0;
      k     <= '0;
      col   <= '0;
      acc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_MAC;
            row   <= '0;
            k     <= '0;
            col   <= '0;
            acc   <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + DOT_PROD_WIDTH'(prod);
          k   <= k + 1'b1;
          if (k == K_LAST) begin
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          acc <= '0;
          k   <= '0;
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              row   <= '0;
              state <= S_DONE;
            end else begin
              row   <= row + 1'b1;
              state <= S_MAC;
            end
          end else begin
            col   <= col + 1'b1;
            state <= S_MAC;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: everything idles at zero unless its state owns it; rst blanks all.
  always_comb begin
    bus.feature_row_addr = '0;
    bus.feature_col_addr = '0;
    bus.weight_col_addr  = '0;
    bus.write_row        = '0;
    bus.write_col        = '0;
    bus.wr_en            = 1'b0;
    bus.fm_wm_in         = '0;
    bus.busy             = 1'b0;
    bus.done             = 1'b0;
    if (!rst) begin
      case (state)
        S_MAC: begin
          bus.feature_row_addr = row;
          bus.feature_col_addr = k;
          bus.weight_col_addr  = col;
          bus.busy             = 1'b1;
        end
        S_WRITE: begin
          bus.wr_en     = 1'b1;
          bus.fm_wm_in  = acc;
          bus.write_row = row;
          bus.write_col = col;
          bus.busy      = 1'b1;
        end
        S_DONE: begin
          bus.done = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fm_wm_mac_sequencer.sv
// Self-checking bench for fm_wm_mac_sequencer: directed and random matrices,
// cycle-by-cycle comparison against an arithmetic timing/result model.
module tb_fm_wm_mac_sequencer;
  localparam int R   = 6;
  localparam int K   = 96;
  localparam int C   = 3;
  localparam int DW  = 5;
  localparam int PW  = 16;
  localparam int RW  = $clog2(R);
  localparam int KW  = $clog2(K);
  localparam int CW  = $clog2(C);
  localparam int RUN = R * C * (K + 1);

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [DW-1:0] feat [0:(1<<RW)-1][0:(1<<KW)-1];
  logic [DW-1:0] wgt  [0:(1<<KW)-1][0:(1<<CW)-1];

  int            err, wr_cnt, done_cnt, done_cyc, wr_row_last, wr_col_last;
  logic [PW-1:0] wr_dat [0:31];

  fm_wm_mac_sequencer_if #(.FEATURE_ROWS(R), .FEATURE_COLS(K), .WEIGHT_COLS(C),
                           .DATA_WIDTH(DW), .DOT_PROD_WIDTH(PW)) bus ();

  fm_wm_mac_sequencer #(.FEATURE_ROWS(R), .FEATURE_COLS(K), .WEIGHT_COLS(C),
                        .DATA_WIDTH(DW), .DOT_PROD_WIDTH(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Asynchronous-read feature and weight memories.
  always_comb begin
    bus.feature_data = feat[bus.feature_row_addr][bus.feature_col_addr];
    bus.weight_data  = wgt[bus.feature_col_addr][bus.weight_col_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_res(input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < K; i++) s += int'(feat[r][i]) * int'(wgt[i][c]);
    return PW'(s);
  endfunction

  // mode 0: all ones, 1: all 31, 2: feature=r / weight=c+1, else random
  task automatic fill(input int mode);
    foreach (feat[i, j]) feat[i][j] = '0;
    foreach (wgt[i, j]) wgt[i][j] = '0;
    for (int r = 0; r < R; r++)
      for (int i = 0; i < K; i++)
        case (mode)
          0: feat[r][i] = DW'(1);
          1: feat[r][i] = DW'(31);
          2: feat[r][i] = DW'(r);
          default: feat[r][i] = DW'($urandom_range(0, 31));
        endcase
    for (int i = 0; i < K; i++)
      for (int c = 0; c < C; c++)
        case (mode)
          0: wgt[i][c] = DW'(1);
          1: wgt[i][c] = DW'(31);
          2: wgt[i][c] = DW'(c + 1);
          default: wgt[i][c] = DW'($urandom_range(0, 31));
        endcase
  endtask

  // Pulse start at a negedge; returns at the negedge of run cycle 0.
  task automatic start_run(input bit hold);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = hold;
  endtask

  // Watch n cycles. Expected outputs per cycle come from the run timeline:
  // element e occupies cycles e*(K+1) .. e*(K+1)+K, its last cycle is the write.
  task automatic observe(input int n, input bit hold, input bit idle_only,
                         input int pa, input int pb);
    err = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int t = 0; t < n; t++) begin
      int tt, elem, kk, r, c;
      logic e_busy, e_done, e_wr;
      logic [RW-1:0] e_fr, e_wrow;
      logic [KW-1:0] e_fc;
      logic [CW-1:0] e_wc, e_wcol;
      logic [PW-1:0] e_dat;
      e_busy = 0; e_done = 0; e_wr = 0; e_fr = '0; e_wrow = '0;
      e_fc = '0; e_wc = '0; e_wcol = '0; e_dat = '0;
      if (!idle_only) begin
        tt = hold ? (t % (RUN + 2)) : t;
        if (tt < RUN) begin
          elem = tt / (K + 1); kk = tt % (K + 1); r = elem / C; c = elem % C;
          e_busy = 1'b1;
          if (kk < K) begin
            e_fr = RW'(r); e_fc = KW'(kk); e_wc = CW'(c);
          end else begin
            e_wr = 1'b1; e_wrow = RW'(r); e_wcol = CW'(c); e_dat = exp_res(r, c);
          end
        end else if (tt == RUN) begin
          e_done = 1'b1;
        end
      end
      if ({bus.busy, bus.done, bus.wr_en, bus.feature_row_addr, bus.feature_col_addr,
           bus.weight_col_addr, bus.write_row, bus.write_col, bus.fm_wm_in} !==
          {e_busy, e_done, e_wr, e_fr, e_fc, e_wc, e_wrow, e_wcol, e_dat}) begin
        if (err == 0)
          $display("first deviation at cycle %0d: busy=%b done=%b wr=%b addr=%0d/%0d/%0d wr=%0d,%0d data=%0d",
                   t, bus.busy, bus.done, bus.wr_en, bus.feature_row_addr, bus.feature_col_addr,
                   bus.weight_col_addr, bus.write_row, bus.write_col, bus.fm_wm_in);
        err++;
      end
      if (bus.wr_en === 1'b1) begin
        if (wr_cnt < 32) wr_dat[wr_cnt] = bus.fm_wm_in;
        wr_row_last = int'(bus.write_row);
        wr_col_last = int'(bus.write_col);
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        if (done_cyc < 0) done_cyc = t;
        done_cnt++;
      end
      bus.start = hold || (t == pa) || (t == pb);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_data", bus.fm_wm_in, 0);
    check("rst_addr", {bus.feature_row_addr, bus.feature_col_addr, bus.weight_col_addr,
                       bus.write_row, bus.write_col}, 0);
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    #1;
    check("rst_priority_busy", bus.busy, 0);
    @(negedge clk);

    // all ones
    start_run(0);
    observe(RUN + 5, 0, 0, -1, -1);
    check("ones_timeline", err, 0);
    check("ones_wr_cnt", wr_cnt, R * C);
    check("ones_done_cnt", done_cnt, 1);
    check("ones_done_cycle", done_cyc, RUN);
    check("ones_first_data", wr_dat[0], 96);
    check("ones_last_elem", {wr_row_last[7:0], wr_col_last[7:0]}, {8'd5, 8'd2});

    // all 31: accumulator wraps
    fill(1);
    start_run(0);
    observe(RUN + 5, 0, 0, -1, -1);
    check("max_timeline", err, 0);
    check("max_data0", wr_dat[0], 26720);
    check("max_data17", wr_dat[17], 26720);

    // feature=r, weight=c+1
    fill(2);
    start_run(0);
    observe(RUN + 5, 0, 0, -1, -1);
    check("ramp_timeline", err, 0);
    check("ramp_res00", wr_dat[0], 0);
    check("ramp_res52", wr_dat[17], 1440);
    check("ramp_res31", wr_dat[10], 96 * 3 * 2);

    // random matrices
    for (int i = 0; i < 2; i++) begin
      fill(3);
      start_run(0);
      observe(RUN + 5, 0, 0, -1, -1);
      check("rand_timeline", err, 0);
      check("rand_wr_cnt", wr_cnt, R * C);
    end

    // start held high: one done, second run right after the idle cycle
    fill(0);
    start_run(1);
    observe(RUN + 2 + 150, 1, 0, -1, -1);
    check("hold_timeline", err, 0);
    check("hold_done_cnt", done_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset during the third element's MAC phase
    start_run(0);
    observe(200, 0, 0, -1, -1);
    check("abort_pre_timeline", err, 0);
    rst = 1'b1;
    #1;
    check("abort_rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    observe(RUN + 20, 0, 1, -1, -1);
    check("abort_idle", err, 0);
    check("abort_wr_cnt", wr_cnt, 0);
    check("abort_done_cnt", done_cnt, 0);
    start_run(0);
    observe(RUN + 5, 0, 0, -1, -1);
    check("rerun_timeline", err, 0);
    check("rerun_wr_cnt", wr_cnt, R * C);
    check("rerun_done_cycle", done_cyc, RUN);

    // start pulses during a WRITE and during DONE are ignored
    start_run(0);
    observe(RUN + 10, 0, 0, K, RUN);
    check("ignore_timeline", err, 0);
    check("ignore_wr_cnt", wr_cnt, R * C);
    check("ignore_done_cnt", done_cnt, 1);
    check("ignore_done_cycle", done_cyc, RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
